// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART echo block: FSM encodings and
// the depth of the RxD synchroniser.
package uart_pkg;

    // Number of flops between the asynchronous RxD pin and the RX logic.
    localparam int SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_IDLE = 3'd4
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO holding received bytes until the transmitter
// takes them. Pointers wrap naturally because DEPTH is a power of two.
//
// Handshake: push is a request qualified internally by !full (or by a
// simultaneous pop, which frees the slot being written); pop is a request
// qualified by !empty. Callers look at full/empty to know whether their
// request takes effect in the current cycle; a rejected request is
// simply ignored.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign wr_en    = push && (!full || pop);
    assign rd_en    = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_echo_buffered.sv
// UART receiver and transmitter joined by a byte FIFO: every good frame
// received while loop_en is high is echoed back on TxD. RX and TX run
// independently; the FIFO absorbs the difference in their timing.
module uart_echo_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         RxD,
    output logic                         TxD,
    input  logic                         loop_en,
    output logic                         frame_err,
    output logic                         overflow,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    // ------------------------------------------------------------------
    // RxD synchroniser
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] rx_sync;
    logic                   rx_s;

    assign rx_s = rx_sync[SYNC_STAGES-1];

    // Shift the raw pin through the synchroniser; resets to the idle level.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync <= '1;
        end else begin
            rx_sync <= {rx_sync[SYNC_STAGES-2:0], RxD};
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    rx_state_t            rx_state, rx_state_n;
    logic [CW-1:0]        rx_cnt, rx_cnt_n;
    logic [IW-1:0]        rx_idx, rx_idx_n;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
    logic                 rx_good_n;
    logic                 rx_ferr_n;
    logic                 push_q;
    logic [DATA_BITS-1:0] push_data_q;

    // RX next-state: half-bit start check, mid-bit data samples, stop check.
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + 1'b1;
        rx_idx_n   = rx_idx;
        rx_shift_n = rx_shift;
        rx_good_n  = 1'b0;
        rx_ferr_n  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                if (!rx_s) begin
                    rx_state_n = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n = '0;
                    rx_idx_n = '0;
                    // A line that is high again by mid-start was a glitch.
                    rx_state_n = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_s, rx_shift[DATA_BITS-1:1]};
                    if (rx_idx == IDX_LAST) begin
                        rx_state_n = RX_STOP;
                    end else begin
                        rx_idx_n = rx_idx + 1'b1;
                    end
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n = '0;
                    if (rx_s) begin
                        rx_good_n  = 1'b1;
                        rx_state_n = RX_IDLE;
                    end else begin
                        rx_ferr_n  = 1'b1;
                        rx_state_n = RX_WAIT_IDLE;
                    end
                end
            end
            RX_WAIT_IDLE: begin
                rx_cnt_n = '0;
                if (rx_s) begin
                    rx_state_n = RX_IDLE;
                end
            end
            default: begin
                rx_cnt_n   = '0;
                rx_state_n = RX_IDLE;
            end
        endcase
    end

    // RX state register plus the registered push request and error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state    <= RX_IDLE;
            rx_cnt      <= '0;
            rx_idx      <= '0;
            rx_shift    <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            frame_err   <= 1'b0;
        end else begin
            rx_state    <= rx_state_n;
            rx_cnt      <= rx_cnt_n;
            rx_idx      <= rx_idx_n;
            rx_shift    <= rx_shift_n;
            push_q      <= rx_good_n && loop_en;
            push_data_q <= rx_shift_n;
            frame_err   <= rx_ferr_n;
        end
    end

    // ------------------------------------------------------------------
    // Echo buffer
    // ------------------------------------------------------------------
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 tx_pop;

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_q),
        .push_data (push_data_q),
        .pop       (tx_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Flag a good byte that the full buffer could not take.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else begin
            overflow <= push_q && fifo_full && !tx_pop;
        end
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_t            tx_state, tx_state_n;
    logic [CW-1:0]        tx_cnt, tx_cnt_n;
    logic [IW-1:0]        tx_idx, tx_idx_n;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
    logic                 txd_n;

    // TX next-state: TxD is registered, so each branch sets the level the
    // line must carry from the coming edge onwards.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + 1'b1;
        tx_idx_n   = tx_idx;
        tx_shift_n = tx_shift;
        txd_n      = TxD;
        tx_pop     = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_n = '0;
                txd_n    = 1'b1;
                if (!fifo_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_n = fifo_rdata;
                    tx_state_n = TX_START;
                    txd_n      = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_idx_n   = '0;
                    tx_state_n = TX_DATA;
                    txd_n      = tx_shift[0];
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    if (tx_idx == IDX_LAST) begin
                        tx_state_n = TX_STOP;
                        txd_n      = 1'b1;
                    end else begin
                        tx_idx_n   = tx_idx + 1'b1;
                        tx_shift_n = tx_shift >> 1;
                        txd_n      = tx_shift[1];
                    end
                end
            end
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    // Chain straight into the next start bit when a byte waits.
                    if (!fifo_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_n = fifo_rdata;
                        tx_state_n = TX_START;
                        txd_n      = 1'b0;
                    end else begin
                        tx_state_n = TX_IDLE;
                        txd_n      = 1'b1;
                    end
                end
            end
            default: begin
                tx_cnt_n   = '0;
                tx_state_n = TX_IDLE;
                txd_n      = 1'b1;
            end
        endcase
    end

    // TX state register; TxD returns high on the first reset edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            TxD      <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_idx   <= tx_idx_n;
            tx_shift <= tx_shift_n;
            TxD      <= txd_n;
        end
    end

endmodule

// File: doc/uart_echo_buffered.md
UART_ECHO_BUFFERED -- requirements
Module: uart_echo_buffered

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200); minimum 4.
REQ-002 SHALL have parameter DATA_BITS, default 8, payload bits per frame (5..9).
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, echo buffer entries (power of 2, >=2).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port RxD  input  1  asynchronous UART receive line, idle high.
REQ-007 SHALL have port TxD  output  1  UART transmit line, idle high.
REQ-008 SHALL have port loop_en  input  1  1 = received bytes are queued for echo; 0 = received bytes are discarded.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port overflow  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
REQ-011 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered.

Function
REQ-012 SHALL pass RxD through a 2-flop synchroniser; all RX decisions use the synchronised value.
REQ-013 RX FSM SHALL have states RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE.
REQ-014 RX_IDLE -> RX_START SHALL occur on a synchronised low.
REQ-015 RX_START SHALL sample at CLKS_PER_BIT/2 cycles: low -> RX_DATA; high -> RX_IDLE (glitch rejected, no flags raised).
REQ-016 RX_DATA SHALL sample DATA_BITS bits, LSB first, each CLKS_PER_BIT cycles after the previous sample (mid-bit).
REQ-017 RX_STOP SHALL sample once, CLKS_PER_BIT after the last data sample: high -> byte valid and RX_IDLE; low -> frame_err pulse, byte discarded, and RX_WAIT_IDLE.
REQ-018 RX_WAIT_IDLE SHALL return to RX_IDLE on the first synchronised high.
REQ-019 A valid byte SHALL be pushed at the stop-sample edge when loop_en=1; with loop_en=0 it SHALL be dropped silently.
REQ-020 A push to a full FIFO SHALL be rejected with an overflow pulse, unless a pop occurs in the same cycle; in that case the push is accepted and fifo_count is unchanged.
REQ-021 TX FSM SHALL have states TX_IDLE, TX_START, TX_DATA, TX_STOP.
REQ-022 TX_IDLE SHALL pop when fifo_count!=0, and TxD SHALL go low on the next edge for exactly CLKS_PER_BIT cycles.
REQ-023 TX SHALL then send DATA_BITS bits LSB first, then stop high, each exactly CLKS_PER_BIT cycles.
REQ-024 TX SHALL return to TX_IDLE after the stop bit; a pending byte SHALL start its start bit the cycle after the stop bit ends (no idle gap).
REQ-025 Latency: push on edge N; fifo_count increments at N+1; pop at N+1; TxD low from N+2.
REQ-026 RX and TX SHALL operate fully concurrently, independent of one another.
REQ-027 fifo_count SHALL never exceed FIFO_DEPTH or underflow; read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-028 Reset SHALL set TxD=1, frame_err=0, overflow=0, fifo_count=0, both FSMs to IDLE, synchroniser flops=1, and all counters to 0.
REQ-029 Reset mid-frame SHALL abort RX and TX; TxD SHALL be high from the first edge with reset asserted, and buffered bytes SHALL be lost.

Structure
REQ-030 RX and TX state encodings and the synchroniser depth constant SHALL live in shared package uart_pkg.
REQ-031 The buffer SHALL be a sub-module uart_fifo (parameters: width, depth; ports: push, pop, full, empty, count).

Verification (CLKS_PER_BIT=4, DATA_BITS=8, FIFO_DEPTH=4)
REQ-032 Send 0xA5 with loop_en=1 -> TxD carries 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first), start bit 2 cycles after the stop sample, frame_err=0.
REQ-033 Send 0x3C with stop bit low -> exactly one frame_err pulse, nothing transmitted, and the next good byte 0x11 is echoed correctly.
REQ-034 Send a 1-cycle low glitch on RxD -> no push, no flags, RX back in idle.
REQ-035 Send 6 back-to-back bytes 0x01..0x06 while TX is busy -> one overflow pulse for 0x06, fifo_count peaks at 4, echo order 0x01..0x05 or 0x01..0x06 per REQ-020 timing.
REQ-036 Assert reset during TX data bit 3 of 0x55 -> TxD=1 next edge, fifo_count=0, and a following byte 0x7E is echoed intact.
REQ-037 Send 0x42 with loop_en=0 -> no transmission, fifo_count stays 0.
